// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the 5-stage pipeline controller.
//   - md_state_e     : mul/div sequencer states
//   - MD_LATENCY_DEF : default mul/div EXE occupancy
//   - STG_*          : stage indices into per-stage vectors (IF=0 .. WB=4)
//   - next_valid()   : stage valid-bit update rule
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int unsigned MD_LATENCY_DEF = 4;

  localparam int unsigned STG_IF     = 0;
  localparam int unsigned STG_DE     = 1;
  localparam int unsigned STG_EXE    = 2;
  localparam int unsigned STG_MEM    = 3;
  localparam int unsigned STG_WB     = 4;
  localparam int unsigned NUM_STAGES = 5;

  // A stage becomes valid when loaded; it empties (bubble) when its
  // instruction leaves and nothing replaces it; otherwise it holds.
  function automatic logic next_valid(input logic valid,
                                      input logic load,
                                      input logic leave);
    if (load)
      return 1'b1;
    else if (valid && leave)
      return 1'b0;
    else
      return valid;
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_ctrl_md_seq.sv
// ---------------------------------------------------------------------------
// md_seq
//   Mul/div occupancy sequencer for the EXE stage.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     start     : valid mul/div instruction sitting in EXE
//     flush     : WB-stage flush; abandon the operation
//     accept    : EXE->MEM load (result consumed)
//     ready     : result available, EXE may advance
//     busy      : sequencer not IDLE
//   Timing: the start cycle, MD_LATENCY-1 BUSY cycles and one DONE cycle give
//   an EXE residency of MD_LATENCY+1 cycles. MD_LATENCY=1 still spends one
//   cycle in BUSY.
// ---------------------------------------------------------------------------
module md_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  input  logic accept,
  output logic ready,
  output logic busy
);

  localparam int unsigned      CNT_W    = $clog2(MD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        // Leave on the last count (1, or 0 when loaded with 0) so the
        // BUSY dwell is MD_LATENCY-1 cycles, minimum one.
        if (cnt_q <= CNT_ONE) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        if (accept) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule : md_seq

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Stage-valid / handshake controller for the IF-DE-EXE-MEM-WB pipeline.
//   Owns stage valid bits, the ready_go/allowin chain and the stage-register
//   load enables; turns load-use stalls, mul/div occupancy, memory wait and
//   WB flush into bubbles.
//   Inputs : clk, rst (sync, active high), if_inst_ok, load_use_stall,
//            exe_is_md, mem_ready, wb_flush
//   Outputs: pc_en, de_en, exe_en, mem_en, wb_en (register load enables),
//            if/de/exe/mem/wb_valid (registered), md_busy,
//            stall_cycles (only with PIPE_PERF_EN)
//   Build option: define PIPE_PERF_EN to add the saturating 32-bit
//   stall_cycles counter and its port.
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_inst_ok,
  input  logic        load_use_stall,
  input  logic        exe_is_md,
  input  logic        mem_ready,
  input  logic        wb_flush,
  output logic        pc_en,
  output logic        de_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        if_valid,
  output logic        de_valid,
  output logic        exe_valid,
  output logic        mem_valid,
  output logic        wb_valid,
  output logic        md_busy
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] ready_go;
  logic                  de_allowin, exe_allowin, mem_allowin, wb_allowin;
  logic                  exe_md, md_ready;

  // Only a valid EXE instruction may start or be held by the sequencer.
  assign exe_md = valid_q[STG_EXE] & exe_is_md;

  md_seq #(.MD_LATENCY(MD_LATENCY)) u_md_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (exe_md),
    .flush  (wb_flush),
    .accept (mem_en),
    .ready  (md_ready),
    .busy   (md_busy)
  );

  assign ready_go[STG_IF]  = if_inst_ok;
  assign ready_go[STG_DE]  = ~load_use_stall;
  assign ready_go[STG_EXE] = ~exe_md | md_ready;
  assign ready_go[STG_MEM] = mem_ready;
  assign ready_go[STG_WB]  = 1'b1;

  // An empty stage always accepts, so a stall in an empty stage is ignored.
  assign wb_allowin  = 1'b1;
  assign mem_allowin = ~valid_q[STG_MEM] | (ready_go[STG_MEM] & wb_allowin);
  assign exe_allowin = ~valid_q[STG_EXE] | (ready_go[STG_EXE] & mem_allowin);
  assign de_allowin  = ~valid_q[STG_DE]  | (ready_go[STG_DE]  & exe_allowin);

  // Flush kills DE/EXE/MEM, so nothing may be loaded into them that cycle.
  assign de_en  = valid_q[STG_IF]  & ready_go[STG_IF]  & de_allowin  & ~wb_flush;
  assign exe_en = valid_q[STG_DE]  & ready_go[STG_DE]  & exe_allowin & ~wb_flush;
  assign mem_en = valid_q[STG_EXE] & ready_go[STG_EXE] & mem_allowin & ~wb_flush;
  assign wb_en  = valid_q[STG_MEM] & ready_go[STG_MEM] & wb_allowin;

  assign pc_en = wb_flush | (valid_q[STG_IF] & ready_go[STG_IF] & de_allowin);

  always_comb begin
    valid_d          = valid_q;
    valid_d[STG_IF]  = 1'b1;
    valid_d[STG_DE]  = next_valid(valid_q[STG_DE],  de_en,
                                  ready_go[STG_DE]  & exe_allowin);
    valid_d[STG_EXE] = next_valid(valid_q[STG_EXE], exe_en,
                                  ready_go[STG_EXE] & mem_allowin);
    valid_d[STG_MEM] = next_valid(valid_q[STG_MEM], mem_en,
                                  ready_go[STG_MEM] & wb_allowin);
    valid_d[STG_WB]  = next_valid(valid_q[STG_WB],  wb_en,
                                  ready_go[STG_WB]);
    if (wb_flush) begin
      valid_d[STG_DE]  = 1'b0;
      valid_d[STG_EXE] = 1'b0;
      valid_d[STG_MEM] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign if_valid  = valid_q[STG_IF];
  assign de_valid  = valid_q[STG_DE];
  assign exe_valid = valid_q[STG_EXE];
  assign mem_valid = valid_q[STG_MEM];
  assign wb_valid  = valid_q[STG_WB];

`ifdef PIPE_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (valid_q[STG_DE] && !exe_en && !wb_flush && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule : pipe_ctrl
